// File: rtl/reg_file_sb.sv
// Register file with per-register scoreboard (busy) bits, optional write-to-read
// forwarding, and a one-register-per-cycle scrub after reset or on request.
module reg_file_sb #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NREG    = 32,
    parameter bit          BYPASS  = 1'b1,
    parameter bit          ZERO_R0 = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr_req,
    output logic                     ready,
    input  logic [$clog2(NREG)-1:0]  A1,
    input  logic [$clog2(NREG)-1:0]  A2,
    output logic [XLEN-1:0]          RD1,
    output logic [XLEN-1:0]          RD2,
    output logic                     busy1,
    output logic                     busy2,
    input  logic                     RegWrite,
    input  logic [$clog2(NREG)-1:0]  A3,
    input  logic [XLEN-1:0]          WD3,
    input  logic                     rsv_en,
    input  logic [$clog2(NREG)-1:0]  rsv_addr
);

    localparam int unsigned AW = $clog2(NREG);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [XLEN-1:0]   regs_q [NREG];
    logic [NREG-1:0]   busy_q;

    logic              scrub_c;
    logic              wr_en_c;
    logic              rsv_en_c;

    // State and scrub index register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state and the array update strobes
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        scrub_c  = 1'b0;
        wr_en_c  = 1'b0;
        rsv_en_c = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                scrub_c = 1'b1;
                idx_d   = idx_q + AW'(1);
                if (idx_q == AW'(NREG - 1)) begin
                    state_d = ST_READY;
                    idx_d   = '0;
                end
            end
            ST_READY: begin
                wr_en_c  = RegWrite && !(ZERO_R0 && (A3 == '0));
                rsv_en_c = rsv_en && !(ZERO_R0 && (rsv_addr == '0));
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                idx_d   = '0;
            end
        endcase
    end

    // Array and scoreboard; a same-cycle reservation overrides the write's busy clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (scrub_c) begin
                regs_q[idx_q] <= '0;
                busy_q[idx_q] <= 1'b0;
            end
            if (wr_en_c) begin
                regs_q[A3] <= WD3;
                busy_q[A3] <= 1'b0;
            end
            if (rsv_en_c) begin
                busy_q[rsv_addr] <= 1'b1;
            end
        end
    end

    assign ready = (state_q == ST_READY);

    // Read port 1
    always_comb begin
        RD1   = '0;
        busy1 = 1'b0;
        if ((state_q == ST_READY) && !(ZERO_R0 && (A1 == '0))) begin
            if (BYPASS && wr_en_c && (A3 == A1)) begin
                RD1 = WD3;
            end else begin
                RD1   = regs_q[A1];
                busy1 = busy_q[A1];
            end
        end
    end

    // Read port 2
    always_comb begin
        RD2   = '0;
        busy2 = 1'b0;
        if ((state_q == ST_READY) && !(ZERO_R0 && (A2 == '0))) begin
            if (BYPASS && wr_en_c && (A3 == A2)) begin
                RD2 = WD3;
            end else begin
                RD2   = regs_q[A2];
                busy2 = busy_q[A2];
            end
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: one forwarding and one non-forwarding
// instance driven by the same stimulus.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr_req;
    logic [4:0]  A1, A2, A3, rsv_addr;
    logic        RegWrite, rsv_en;
    logic [31:0] WD3;

    logic        ready, busy1, busy2;
    logic [31:0] RD1, RD2;
    logic        nb_ready, nb_busy1, nb_busy2;
    logic [31:0] nb_RD1, nb_RD2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.XLEN(32), .NREG(32), .BYPASS(1'b1), .ZERO_R0(1'b1)) dut (
        .clk(clk), .reset(reset), .clr_req(clr_req), .ready(ready),
        .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .busy1(busy1), .busy2(busy2),
        .RegWrite(RegWrite), .A3(A3), .WD3(WD3), .rsv_en(rsv_en), .rsv_addr(rsv_addr)
    );

    reg_file_sb #(.XLEN(32), .NREG(32), .BYPASS(1'b0), .ZERO_R0(1'b1)) dut_nb (
        .clk(clk), .reset(reset), .clr_req(clr_req), .ready(nb_ready),
        .A1(A1), .A2(A2), .RD1(nb_RD1), .RD2(nb_RD2), .busy1(nb_busy1), .busy2(nb_busy2),
        .RegWrite(RegWrite), .A3(A3), .WD3(WD3), .rsv_en(rsv_en), .rsv_addr(rsv_addr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until ready rises (bounded) and compare against the expected count
    task automatic wait_ready(input string tag, input int exp_edges);
        int cnt = 0;
        while (!ready && cnt < 100) begin
            tick();
            cnt++;
        end
        check(tag, 32'(cnt), 32'(exp_edges));
        check({tag, "_nb_ready"}, {31'd0, nb_ready}, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        for (int a = 0; a < 32; a++) begin
            A1 = 5'(a);
            A2 = 5'(31 - a);
            #1;
            check({tag, "_rd1"}, RD1, 32'd0);
            check({tag, "_rd2"}, RD2, 32'd0);
            check({tag, "_busy1"}, {31'd0, busy1}, 32'd0);
            check({tag, "_nb_rd1"}, nb_RD1, 32'd0);
        end
    endtask

    function automatic logic [31:0] fill_val(input int a);
        return 32'h1000_0000 + 32'(a * 3 + 1);
    endfunction

    initial begin
        reset = 1'b1; clr_req = 1'b0; RegWrite = 1'b0; rsv_en = 1'b0;
        A1 = '0; A2 = '0; A3 = '0; rsv_addr = '0; WD3 = '0;

        // Reset, then writes/reservations/clr_req during the scrub must be ignored
        tick();
        reset = 1'b0;
        check("ready_after_reset", {31'd0, ready}, 32'd0);
        RegWrite = 1'b1; A3 = 5'd5; WD3 = 32'hFFFF_FFFF; A1 = 5'd5;
        rsv_en = 1'b1; rsv_addr = 5'd6; clr_req = 1'b1; A2 = 5'd6;
        #1;
        check("clear_rd1", RD1, 32'd0);
        check("clear_busy2", {31'd0, busy2}, 32'd0);
        tick(); tick(); tick();
        RegWrite = 1'b0; rsv_en = 1'b0; clr_req = 1'b0;
        wait_ready("scrub_len_reset", 29);
        check_all_zero("post_reset");

        // Same-cycle write and read of r5
        RegWrite = 1'b1; A3 = 5'd5; WD3 = 32'hDEAD_BEEF; A1 = 5'd5;
        #1;
        check("bypass_rd1", RD1, 32'hDEAD_BEEF);
        check("bypass_busy1", {31'd0, busy1}, 32'd0);
        check("nobypass_rd1", nb_RD1, 32'd0);
        tick();
        RegWrite = 1'b0;
        #1;
        check("next_rd1", RD1, 32'hDEAD_BEEF);
        check("nb_next_rd1", nb_RD1, 32'hDEAD_BEEF);

        // Reservation, release by write, and same-cycle write+reserve on r7
        rsv_en = 1'b1; rsv_addr = 5'd7; A1 = 5'd7; A2 = 5'd7;
        #1;
        check("rsv_no_forward", {31'd0, busy1}, 32'd0);
        tick();
        rsv_en = 1'b0;
        #1;
        check("rsv_busy1", {31'd0, busy1}, 32'd1);
        check("rsv_busy2", {31'd0, busy2}, 32'd1);
        check("nb_rsv_busy1", {31'd0, nb_busy1}, 32'd1);
        RegWrite = 1'b1; A3 = 5'd7; WD3 = 32'h0000_0077;
        #1;
        check("wr_fwd_busy1", {31'd0, busy1}, 32'd0);
        check("wr_fwd_rd2", RD2, 32'h0000_0077);
        check("nb_wr_busy1", {31'd0, nb_busy1}, 32'd1);
        tick();
        RegWrite = 1'b0;
        #1;
        check("release_busy1", {31'd0, busy1}, 32'd0);
        check("nb_release_busy1", {31'd0, nb_busy1}, 32'd0);
        check("release_rd1", RD1, 32'h0000_0077);
        RegWrite = 1'b1; rsv_en = 1'b1; A3 = 5'd7; rsv_addr = 5'd7; WD3 = 32'hA5A5_A5A5;
        tick();
        RegWrite = 1'b0; rsv_en = 1'b0;
        #1;
        check("wr_rsv_busy1", {31'd0, busy1}, 32'd1);
        check("wr_rsv_rd1", RD1, 32'hA5A5_A5A5);
        check("nb_wr_rsv_busy1", {31'd0, nb_busy1}, 32'd1);

        // Writes and reservations to r0 are dropped
        RegWrite = 1'b1; A3 = 5'd0; WD3 = 32'h0000_1234; rsv_en = 1'b1; rsv_addr = 5'd0; A1 = 5'd0;
        #1;
        check("r0_same_rd1", RD1, 32'd0);
        check("r0_same_busy1", {31'd0, busy1}, 32'd0);
        tick();
        RegWrite = 1'b0; rsv_en = 1'b0;
        #1;
        check("r0_rd1", RD1, 32'd0);
        check("r0_busy1", {31'd0, busy1}, 32'd0);
        check("nb_r0_rd1", nb_RD1, 32'd0);

        // Fill r1..r31 and read everything back
        for (int a = 1; a < 32; a++) begin
            RegWrite = 1'b1; A3 = 5'(a); WD3 = fill_val(a);
            tick();
        end
        RegWrite = 1'b0;
        for (int a = 0; a < 32; a++) begin
            A1 = 5'(a);
            #1;
            check("fill_rd1", RD1, (a == 0) ? 32'd0 : fill_val(a));
        end

        // Scrub request; a write in the request cycle lands but is then scrubbed
        rsv_en = 1'b1; rsv_addr = 5'd9; clr_req = 1'b1;
        RegWrite = 1'b1; A3 = 5'd3; WD3 = 32'h0000_CAFE; A1 = 5'd9;
        tick();
        rsv_en = 1'b0; clr_req = 1'b0; RegWrite = 1'b0;
        #1;
        check("clr_ready", {31'd0, ready}, 32'd0);
        check("clr_rd1", RD1, 32'd0);
        wait_ready("scrub_len_clr", 32);
        check_all_zero("post_clr");

        // Reset at idx 10 restarts the full scrub
        RegWrite = 1'b1; A3 = 5'd12; WD3 = 32'h0BAD_F00D;
        tick();
        RegWrite = 1'b0; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_reset_ready", {31'd0, ready}, 32'd0);
        wait_ready("scrub_len_midreset", 32);
        check_all_zero("post_midreset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
